// File: rtl/enc_dec_op_sequencer_if.sv
// Bus bundle between the register file / top level and enc_dec_op_sequencer.
// The master drives the command side and the slave (the sequencer) returns results.
interface enc_dec_op_sequencer_if #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
);
    logic                   start;
    logic [DATA_WIDTH-1:0]  ctrl;
    logic [DATA_WIDTH-1:0]  data_in;
    logic [DATA_WIDTH-1:0]  codeword_width;
    logic [DATA_WIDTH-1:0]  noise;
    logic [DATA_WIDTH-1:0]  data_out;
    logic [1:0]             num_of_errors;
    logic                   operation_done;
    logic                   busy;
    logic [2*CNT_WIDTH-1:0] err_stats;

    modport master (
        output start, ctrl, data_in, codeword_width, noise,
        input  data_out, num_of_errors, operation_done, busy, err_stats
    );

    modport slave (
        input  start, ctrl, data_in, codeword_width, noise,
        output data_out, num_of_errors, operation_done, busy, err_stats
    );
endinterface

// File: rtl/enc_dec_op_sequencer.sv
// Extended-Hamming (SECDED) operation sequencer: encode, decode, or full channel
// (encode, XOR noise, decode), one operation per start pulse, N = 8/16/32.
// Optional macro STAT_CNT_EN builds saturating single/double error counters
// reported on err_stats; without it err_stats is tied to zero.
module enc_dec_op_sequencer #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                   clk,
    input  logic                   rstn,
    enc_dec_op_sequencer_if.slave  bus
);

    typedef enum logic [2:0] {IDLE, ENC, NOISE, DEC, DONE} state_t;

    state_t                  state;
    logic [1:0]              op_q;
    logic [1:0]              width_q;
    logic [DATA_WIDTH-1:0]   data_q;
    logic [DATA_WIDTH-1:0]   noise_q;
    logic [DATA_WIDTH-1:0]   cw_q;
    logic [DATA_WIDTH-1:0]   data_out_q;
    logic [1:0]              errs_q;
    logic                    done_q;
    logic                    busy_q;

    int                      n_cur;
    logic [DATA_WIDTH-1:0]   enc_res;
    logic [DATA_WIDTH+1:0]   dec_res;

    // Only the low two bits of ctrl and codeword_width carry meaning.
    logic unused_cfg;
    assign unused_cfg = ^{bus.ctrl[DATA_WIDTH-1:2], bus.codeword_width[DATA_WIDTH-1:2]};

    // Codeword length for a width code; the illegal code never reaches a datapath use.
    function automatic int width_to_n(input logic [1:0] w);
        case (w)
            2'b00:   return 8;
            2'b01:   return 16;
            default: return 32;
        endcase
    endfunction

    function automatic logic [DATA_WIDTH-1:0] width_mask(input int n);
        logic [DATA_WIDTH-1:0] m;
        m = '0;
        for (int j = 0; j < DATA_WIDTH; j++) m[j] = (j < n);
        return m;
    endfunction

    // Index 0 is overall parity, powers of two are Hamming parity, the rest carry data.
    function automatic logic [DATA_WIDTH-1:0] hamming_encode(input logic [DATA_WIDTH-1:0] d,
                                                             input int n);
        logic [DATA_WIDTH-1:0] cw;
        int   k;
        int   p;
        logic par;
        cw = '0;
        k  = 0;
        for (int j = 3; j < DATA_WIDTH; j++) begin
            if (j < n && (j & (j - 1)) != 0) begin
                cw[j] = d[k];
                k++;
            end
        end
        for (int b = 0; b < 5; b++) begin
            p = 1 << b;
            if (p < n && p < DATA_WIDTH) begin
                par = 1'b0;
                for (int j = 3; j < DATA_WIDTH; j++)
                    if (j < n && (j & p) != 0) par = par ^ cw[j];
                cw[p] = par;
            end
        end
        cw[0] = ^cw;
        return cw;
    endfunction

    // Returns {errors, extracted data}; a single error is corrected before extraction.
    function automatic logic [DATA_WIDTH+1:0] hamming_decode(input logic [DATA_WIDTH-1:0] cw_in,
                                                             input int n);
        logic [DATA_WIDTH-1:0] cw;
        logic [DATA_WIDTH-1:0] d;
        logic [1:0]            errs;
        logic                  par;
        int                    s;
        int                    k;
        cw  = cw_in;
        s   = 0;
        par = 1'b0;
        for (int j = 0; j < DATA_WIDTH; j++) begin
            if (j < n && cw[j]) begin
                par = ~par;
                s   = s ^ j;
            end
        end
        if (par) begin
            cw[s] = ~cw[s];
            errs  = 2'd1;
        end else if (s != 0) begin
            errs = 2'd2;
        end else begin
            errs = 2'd0;
        end
        d = '0;
        k = 0;
        for (int j = 3; j < DATA_WIDTH; j++) begin
            if (j < n && (j & (j - 1)) != 0) begin
                d[k] = cw[j];
                k++;
            end
        end
        return {errs, d};
    endfunction

    // Datapath results for the snapshotted width, consumed by the ENC and DEC states.
    always_comb begin
        n_cur   = width_to_n(width_q);
        enc_res = hamming_encode(data_q, n_cur);
        dec_res = hamming_decode(cw_q, n_cur);
    end

    // Operation FSM with registered outputs and input snapshots.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            op_q       <= '0;
            width_q    <= '0;
            data_q     <= '0;
            noise_q    <= '0;
            cw_q       <= '0;
            data_out_q <= '0;
            errs_q     <= '0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        op_q    <= bus.ctrl[1:0];
                        width_q <= bus.codeword_width[1:0];
                        data_q  <= bus.data_in;
                        noise_q <= bus.noise;
                        busy_q  <= 1'b1;
                        if (bus.ctrl[1:0] == 2'b11 || bus.codeword_width[1:0] == 2'b11) begin
                            data_out_q <= '0;
                            errs_q     <= 2'd3;
                            done_q     <= 1'b1;
                            state      <= DONE;
                        end else if (bus.ctrl[1:0] == 2'b01) begin
                            cw_q  <= bus.data_in &
                                     width_mask(width_to_n(bus.codeword_width[1:0]));
                            state <= DEC;
                        end else begin
                            state <= ENC;
                        end
                    end
                end
                ENC: begin
                    cw_q <= enc_res;
                    if (op_q == 2'b00) begin
                        data_out_q <= enc_res;
                        errs_q     <= 2'd0;
                        done_q     <= 1'b1;
                        state      <= DONE;
                    end else begin
                        state <= NOISE;
                    end
                end
                NOISE: begin
                    cw_q  <= cw_q ^ (noise_q & width_mask(n_cur));
                    state <= DEC;
                end
                DEC: begin
                    data_out_q <= dec_res[DATA_WIDTH-1:0];
                    errs_q     <= dec_res[DATA_WIDTH+1:DATA_WIDTH];
                    done_q     <= 1'b1;
                    state      <= DONE;
                end
                DONE: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.data_out       = data_out_q;
    assign bus.num_of_errors  = errs_q;
    assign bus.operation_done = done_q;
    assign bus.busy           = busy_q;

`ifdef STAT_CNT_EN
    logic [CNT_WIDTH-1:0] single_cnt;
    logic [CNT_WIDTH-1:0] double_cnt;

    // Saturating error statistics, counted as each decode result enters DONE.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            single_cnt <= '0;
            double_cnt <= '0;
        end else if (state == DEC) begin
            if (dec_res[DATA_WIDTH+1:DATA_WIDTH] == 2'd1 && single_cnt != '1)
                single_cnt <= single_cnt + 1'b1;
            if (dec_res[DATA_WIDTH+1:DATA_WIDTH] == 2'd2 && double_cnt != '1)
                double_cnt <= double_cnt + 1'b1;
        end
    end

    assign bus.err_stats = {double_cnt, single_cnt};
`else
    assign bus.err_stats = {(2*CNT_WIDTH){1'b0}};
`endif

endmodule

// File: doc/enc_dec_op_sequencer.md
Name: enc_dec_op_sequencer

Overview:
- Consumes the APB register-file outputs `ctrl`, `data_in`, `codeword_width` and `noise`.
- Executes one extended-Hamming (SECDED) operation per start pulse:
  - encode;
  - decode;
  - full channel: encode, then XOR noise, then decode.
- Multi-cycle FSM, fed directly by the register file.
- Returns `data_out`, `num_of_errors` and an `operation_done` pulse to the top level.

Parameters:
- DATA_WIDTH, 32, width of register inputs and data_out.
- CNT_WIDTH, 16, width of statistics counters (optional feature only).

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse, top-level decode of an APB write to ctrl (psel&penable&pwrite, addr 0)
- ctrl  in  DATA_WIDTH  [1:0] op: 00 encode, 01 decode, 10 full channel, 11 illegal
- data_in  in  DATA_WIDTH  data word (encode) or received codeword (decode)
- codeword_width  in  DATA_WIDTH  [1:0]: 00 N=8, 01 N=16, 10 N=32, 11 illegal
- noise  in  DATA_WIDTH  error mask, full-channel only, bits [N-1:0]
- data_out  out  DATA_WIDTH  result
- num_of_errors  out  2  0 none, 1 corrected, 2 double detected, 3 illegal command
- operation_done  out  1  one-cycle result-valid pulse
- busy  out  1  operation in progress
- err_stats  out  2*CNT_WIDTH  {double_cnt, single_cnt}; zero unless STAT_CNT_EN

Behaviour:
- Reset is `rstn`, asynchronous, active-low; clock is `clk`.
- While `rstn` is low:
  - state is IDLE;
  - data_out, num_of_errors, operation_done, busy, err_stats and all internal snapshots are 0.
  - A reset asserted mid-operation aborts the operation; no done pulse is produced.

Code definition, codeword index i = 0..N-1:
- Bit 0 is the overall even parity over all N bits.
- Bits 1, 2, 4, 8, 16 (those < N) are Hamming parity bit p. Each is the XOR of every index j in 3..N-1 with (j & p) != 0.
- All other indices carry data_in bits in ascending order, starting at data_in[0].
- Data widths are 4, 11 and 26. Unused data_in bits are ignored.
- Encode output is the codeword, zero-extended to DATA_WIDTH.

Decode:
- s = XOR of all indices j in 1..N-1 whose bit is 1.
- P = XOR of all N bits.
- s=0, P=0: no error; errors=0.
- P=1: single error at index s (s=0 means bit 0). Flip that bit, extract data; errors=1.
- s≠0, P=0: double error. Extract data from the uncorrected word; errors=2.
- Extracted data is zero-extended into data_out.

FSM states: IDLE, ENC, NOISE, DEC, DONE.
- IDLE:
  - `start` snapshots ctrl[1:0], codeword_width[1:0], data_in and noise.
  - If op or width is illegal, go to DONE.
  - Op 00 or 10: go to ENC.
  - Op 01: load the internal codeword register from data_in[N-1:0] (upper bits zeroed), then go to DEC.
- ENC: cw <= encode(data). Op 00 goes to DONE; op 10 goes to NOISE.
- NOISE: cw <= cw ^ noise[N-1:0]; go to DEC.
- DEC: compute s and P, correct and extract into result registers; go to DONE.
- DONE:
  - operation_done=1 for exactly this cycle.
  - data_out and num_of_errors update on entry to DONE and hold until the next DONE entry.
  - Illegal command: data_out=0, num_of_errors=3.
  - Next state is IDLE.

Handshake and timing:
- busy is high from the cycle after `start` is sampled through the DONE cycle inclusive.
- Latency from the `start` sample edge to the operation_done cycle:
  - encode: 2 cycles;
  - decode: 2 cycles;
  - full channel: 4 cycles;
  - illegal command: 1 cycle.
- `start` while busy is ignored; no queueing.
- Register-file writes during busy do not affect the current operation, because inputs are snapshotted.
- Back-to-back operation: a `start` in the cycle after DONE (FSM in IDLE) is accepted.

Optional Feature:
- Macro: STAT_CNT_EN.
- When defined:
  - single_cnt increments on every DONE with errors=1;
  - double_cnt increments on every DONE with errors=2;
  - both saturate at all-ones and are cleared only by reset.
- When undefined: err_stats is tied to 0 and no counter flops are built.

Test Plan:
- Encode: width 00, op 00, data_in=0x0000000B, start → 2 cycles later operation_done=1, data_out=0x000000AA, num_of_errors=0.
- Decode, clean and single error:
  - data_in=0xAA, op 01 → data_out=0xB, errors=0.
  - data_in=0xAB (bit 0 flipped) → data_out=0xB, errors=1.
- Full channel: data_in=0xB, width 00, op 10.
  - noise=0x20 → done 4 cycles after start, data_out=0xB, errors=1.
  - noise=0x60 → data_out=0xD (uncorrected), errors=2.
- Illegal command: op 11 → done 1 cycle after start, data_out=0, errors=3. Separately, width 11 → same response.
- start asserted while busy, plus a data_in change mid-operation → second start ignored; result matches the snapshot; exactly one operation_done pulse.
- Reset and statistics:
  - rstn low during NOISE → all outputs 0, no operation_done pulse.
  - With STAT_CNT_EN, run single-error then double-error → err_stats = {1,1}.
